ecc_apb_ctrl: RTL and testbench



---
 rtl/ecc_apb_ctrl_pkg.sv | 34 +++
 rtl/ecc_apb_ctrl_if.sv | 24 ++
 rtl/ecc_apb_ctrl_regs.sv | 100 ++++++++++
 rtl/ecc_apb_ctrl.sv | 86 ++++++++
 tb/tb_ecc_apb_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_apb_ctrl_pkg.sv
// Shared definitions for the ECC APB controller: register offsets,
// codeword-width encoding, sequencer states and the width mask helper.
package ecc_pkg;

  localparam logic [4:0] CTRL_ADDR     = 5'h00;
  localparam logic [4:0] DATA_IN_ADDR  = 5'h04;
  localparam logic [4:0] CW_ADDR       = 5'h08;
  localparam logic [4:0] NOISE_ADDR    = 5'h0C;
  localparam logic [4:0] DATA_OUT_ADDR = 5'h10;
  localparam logic [4:0] STATUS_ADDR   = 5'h14;

  typedef enum logic [1:0] {
    CW_8  = 2'b00,
    CW_16 = 2'b01,
    CW_32 = 2'b10
  } cw_e;

  typedef enum logic {
    IDLE = 1'b0,
    ENC  = 1'b1
  } state_e;

  // CW=11 behaves like the full-width setting.
  function automatic logic [31:0] cw_mask(input logic [1:0] cw);
    logic [31:0] m;
    case (cw)
      CW_8:    m = 32'h0000_00FF;
      CW_16:   m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ecc_apb_ctrl_if.sv
// APB bus bundle between a master (software side) and the ECC controller.
interface ecc_apb_ctrl_if #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
);
  logic [AMBA_ADDR_WIDTH-1:0] paddr;
  logic                       psel;
  logic                       penable;
  logic                       pwrite;
  logic [AMBA_WORD-1:0]       pwdata;
  logic [AMBA_WORD-1:0]       prdata;
  logic                       pready;
  logic                       pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ecc_apb_ctrl_regs.sv
// APB decode, configuration register storage and error response.
module ecc_apb_regs
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_apb_ctrl_if.slave         apb,
  input  logic                  busy,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  start_req,
  output logic                  ctrl_wr,
  output logic                  noise_en,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] noise,
  output logic [1:0]            cw
);

  logic                  access, wr_ok, cfg_hit, ro_hit;
  logic [4:0]            offset;
  logic [AMBA_WORD-1:0]  rdata;
  logic                  noise_en_q, noise_en_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;
  logic [1:0]            cw_q, cw_d;
  logic                  unused_addr_bits;

  assign offset           = {apb.paddr[4:2], 2'b00};
  assign unused_addr_bits = ^{apb.paddr[AMBA_ADDR_WIDTH-1:5], apb.paddr[1:0]};

  // Config writes are refused while the sequencer is busy.
  always_comb begin
    access      = apb.psel & apb.penable;
    cfg_hit     = offset inside {CTRL_ADDR, DATA_IN_ADDR, CW_ADDR, NOISE_ADDR};
    ro_hit      = offset inside {DATA_OUT_ADDR, STATUS_ADDR};
    apb.pready  = access;
    apb.pslverr = 1'b0;
    if (access)
      apb.pslverr = apb.pwrite ? (!cfg_hit || busy) : !(cfg_hit || ro_hit);
    wr_ok     = access & apb.pwrite & cfg_hit & ~busy;
    ctrl_wr   = wr_ok && (offset == CTRL_ADDR);
    start_req = ctrl_wr && apb.pwdata[0];
  end

  always_comb begin
    rdata = '0;
    if (apb.psel && apb.penable && !apb.pwrite) begin
      case (offset)
        CTRL_ADDR:     rdata[1] = noise_en_q;
        DATA_IN_ADDR:  rdata[DATA_WIDTH-1:0] = data_in_q;
        CW_ADDR:       rdata[1:0] = cw_q;
        NOISE_ADDR:    rdata[DATA_WIDTH-1:0] = noise_q;
        DATA_OUT_ADDR: rdata[DATA_WIDTH-1:0] = data_out;
        STATUS_ADDR:   rdata[1:0] = {done, busy};
        default:       rdata = '0;
      endcase
    end
    apb.prdata = rdata;
  end

  always_comb begin
    noise_en_d = noise_en_q;
    data_in_d  = data_in_q;
    noise_d    = noise_q;
    cw_d       = cw_q;
    if (wr_ok) begin
      case (offset)
        CTRL_ADDR:    noise_en_d = apb.pwdata[1];
        DATA_IN_ADDR: data_in_d  = apb.pwdata[DATA_WIDTH-1:0];
        CW_ADDR:      cw_d       = apb.pwdata[1:0];
        NOISE_ADDR:   noise_d    = apb.pwdata[DATA_WIDTH-1:0];
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise_en_q <= 1'b0;
      data_in_q  <= '0;
      noise_q    <= '0;
      cw_q       <= '0;
    end else begin
      noise_en_q <= noise_en_d;
      data_in_q  <= data_in_d;
      noise_q    <= noise_d;
      cw_q       <= cw_d;
    end
  end

  assign noise_en = noise_en_q;
  assign data_in  = data_in_q;
  assign noise    = noise_q;
  assign cw       = cw_q;

endmodule

// File: rtl/ecc_apb_ctrl.sv
// APB-controlled sequencer that fires the Hamming encoder for one cycle
// and captures its masked, optionally noise-corrupted result.
module ecc_apb_ctrl
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_apb_ctrl_if.slave         apb,
  output logic                  enc_ena,
  output logic [1:0]            enc_codeword_width,
  output logic [DATA_WIDTH-1:0] enc_data_in,
  input  logic [DATA_WIDTH-1:0] enc_data_out
);

  state_e                state_q, state_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  busy, start_req, ctrl_wr, noise_en;
  logic [DATA_WIDTH-1:0] data_in, noise;
  logic [1:0]            cw;
  logic [31:0]           mask32;

  ecc_apb_regs #(
    .DATA_WIDTH      (DATA_WIDTH),
    .AMBA_WORD       (AMBA_WORD),
    .AMBA_ADDR_WIDTH (AMBA_ADDR_WIDTH)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .apb       (apb),
    .busy      (busy),
    .done      (done_q),
    .data_out  (data_out_q),
    .start_req (start_req),
    .ctrl_wr   (ctrl_wr),
    .noise_en  (noise_en),
    .data_in   (data_in),
    .noise     (noise),
    .cw        (cw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  // Any accepted CTRL write clears done; completing ENC sets it.
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    data_out_d = data_out_q;
    mask32     = cw_mask(cw);
    case (state_q)
      IDLE: begin
        if (ctrl_wr)   done_d  = 1'b0;
        if (start_req) state_d = ENC;
      end
      ENC: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        data_out_d = (enc_data_out ^ (noise_en ? noise : '0)) & mask32[DATA_WIDTH-1:0];
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == ENC);
    enc_ena = (state_q == ENC);
  end

  assign enc_codeword_width = cw;
  assign enc_data_in        = data_in;

endmodule

// File: tb/tb_ecc_apb_ctrl.sv
// Scoreboard bench for ecc_apb_ctrl: a transaction-level register model
// predicts every APB response and a negedge monitor compares them.
module tb_ecc_apb_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int ADW = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ecc_apb_ctrl_if #(.AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW)) apb ();

  logic          enc_ena;
  logic [1:0]    enc_cw;
  logic [DW-1:0] enc_din, enc_dout;

  // Stand-in encoder: any fixed function with busy upper bits will do.
  function automatic logic [31:0] enc_fn(input logic [31:0] d, input logic [1:0] w);
    return {d[15:0], d[31:16]} ^ (32'h9E37_79B9 + {30'b0, w});
  endfunction

  assign enc_dout = enc_fn(enc_din, enc_cw);

  ecc_apb_ctrl #(.DATA_WIDTH(DW), .AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW)) dut (
    .clk                (clk),
    .rst                (rst),
    .apb                (apb),
    .enc_ena            (enc_ena),
    .enc_codeword_width (enc_cw),
    .enc_data_in        (enc_din),
    .enc_data_out       (enc_dout)
  );

  typedef struct {
    bit          wr;
    logic [4:0]  off;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cyc = -10;

  logic [31:0] m_data, m_noise, m_out, m_out_old;
  logic [1:0]  m_cw;
  bit          m_noise_en, m_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [1:0] w);
    if (w == 2'd0) return 32'd255;
    if (w == 2'd1) return 32'd65535;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    m_data = '0; m_noise = '0; m_out = '0; m_out_old = '0;
    m_cw = '0; m_noise_en = 1'b0; m_done = 1'b0;
    start_cyc = -10;
  endtask

  // fast=1 skips the setup phase so the access lands in the cycle right after the previous edge.
  task automatic apply_stimulus(input bit wr, input logic [4:0] off, input logic [31:0] data, input bit fast);
    logic [31:0] r;
    exp_t        e;
    bit          busy;
    r = $urandom();
    if (!fast) begin
      @(posedge clk); #1;
      apb.psel = 1'b1; apb.penable = 1'b0;
      apb.paddr = {r[14:0], off[4:2], r[16:15]};
      apb.pwrite = wr; apb.pwdata = data;
      @(posedge clk); #1;
      apb.penable = 1'b1;
    end else begin
      apb.psel = 1'b1; apb.penable = 1'b1;
      apb.paddr = {r[14:0], off[4:2], r[16:15]};
      apb.pwrite = wr; apb.pwdata = data;
    end
    busy    = (cyc == start_cyc);
    e.wr    = wr;
    e.off   = {off[4:2], 2'b00};
    e.rdata = '0;
    if (wr) begin
      e.err = (e.off > 5'h0C) || busy;
    end else begin
      e.err = (e.off > 5'h14);
      case (e.off)
        5'h00: e.rdata = {30'b0, m_noise_en, 1'b0};
        5'h04: e.rdata = m_data;
        5'h08: e.rdata = {30'b0, m_cw};
        5'h0C: e.rdata = m_noise;
        5'h10: e.rdata = busy ? m_out_old : m_out;
        5'h14: e.rdata = busy ? 32'd1 : {30'b0, m_done, 1'b0};
        default: e.rdata = '0;
      endcase
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
    if (wr && !e.err) begin
      case (e.off)
        5'h00: begin
          m_noise_en = data[1];
          m_done     = 1'b0;
          if (data[0]) begin
            m_out_old = m_out;
            m_out     = (enc_fn(m_data, m_cw) ^ (m_noise_en ? m_noise : 32'd0)) & mask_of(m_cw);
            m_done    = 1'b1;
            start_cyc = cyc;
          end
        end
        5'h04: m_data  = data;
        5'h08: m_cw    = data[1:0];
        5'h0C: m_noise = data;
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_output("enc_ena", {31'b0, enc_ena}, (cyc == start_cyc) ? 32'd1 : 32'd0);
      if (apb.psel && apb.penable) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("[TB] FAIL unexpected_xfer: got access phase, expected none queued");
        end else begin
          mon_e = sb_q.pop_front();
          check_output("pready", {31'b0, apb.pready}, 32'd1);
          check_output($sformatf("pslverr@%h", mon_e.off), {31'b0, apb.pslverr}, {31'b0, mon_e.err});
          if (!mon_e.wr)
            check_output($sformatf("prdata@%h", mon_e.off), apb.prdata, mon_e.rdata);
        end
      end else begin
        check_output("idle_resp", {30'b0, apb.pready, apb.pslverr}, 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic [4:0]  off;
    rst = 1'b1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset contents of every offset, mapped and unmapped.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 5'(i * 4), 32'd0, 1'b0);

    // 8-bit codeword, status sampled during and after ENC.
    apply_stimulus(1'b1, 5'h04, 32'h0000_000B, 1'b0);
    apply_stimulus(1'b1, 5'h08, 32'h0, 1'b0);
    apply_stimulus(1'b1, 5'h00, 32'h1, 1'b0);
    apply_stimulus(1'b0, 5'h14, 32'h0, 1'b1);
    apply_stimulus(1'b0, 5'h10, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h14, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h00, 32'h0, 1'b0);

    // Full width with noise injection.
    apply_stimulus(1'b1, 5'h04, 32'h03FF_FFFF, 1'b0);
    apply_stimulus(1'b1, 5'h08, 32'h2, 1'b0);
    apply_stimulus(1'b1, 5'h0C, 32'h4, 1'b0);
    apply_stimulus(1'b1, 5'h00, 32'h3, 1'b0);
    apply_stimulus(1'b0, 5'h10, 32'h0, 1'b0);

    // Config write landing in the ENC cycle must be rejected.
    apply_stimulus(1'b1, 5'h08, 32'h1, 1'b0);
    apply_stimulus(1'b1, 5'h00, 32'h1, 1'b0);
    apply_stimulus(1'b1, 5'h04, 32'hDEAD_BEEF, 1'b1);
    apply_stimulus(1'b0, 5'h04, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h10, 32'h0, 1'b0);

    // Read-only and unmapped offsets.
    apply_stimulus(1'b1, 5'h10, 32'h1234_5678, 1'b0);
    apply_stimulus(1'b0, 5'h1C, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h10, 32'h0, 1'b0);

    // Reset during ENC drops enc_ena without waiting for a clock.
    apply_stimulus(1'b1, 5'h00, 32'h1, 1'b0);
    check_output("enc_ena_in_enc", {31'b0, enc_ena}, 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    check_output("enc_ena_async_rst", {31'b0, enc_ena}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    apply_stimulus(1'b0, 5'h14, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h10, 32'h0, 1'b0);
    apply_stimulus(1'b0, 5'h04, 32'h0, 1'b0);

    // Random traffic across the whole map.
    for (int i = 0; i < 300; i++) begin
      r   = $urandom();
      off = 5'({r[2:0], 2'b00});
      if (r[5:3] == 3'd0) off = 5'h00;
      apply_stimulus(r[6], off, (off == 5'h00) ? {30'b0, r[8:7]} : $urandom(), (r[10:9] == 2'd0));
    end

    repeat (3) @(posedge clk);
    #1;
    check_output("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
